seg7_to_binary: RTL and testbench

//  Input-side counterpart of the multiply-and-display path: accepts NDIG active-low 7-segment

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/seg7_to_binary.sv | 140 ++++++++++++++
 tb/tb_seg7_to_binary.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment codes, FSM state type and the BCD correction step used by
// the seven-segment to binary converter.
package seg7_pkg;

    // Active-low gfedcba patterns.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_9_ALT = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_DONE
    } s2b_state_t;

    // Reverse double-dabble correction: only applied at >= 8, so it cannot wrap.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd8) ? (nib - 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one active-low seven-segment pattern to a BCD digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0, SEG_BLANK: digit = 4'd0;
            SEG_1:            digit = 4'd1;
            SEG_2:            digit = 4'd2;
            SEG_3:            digit = 4'd3;
            SEG_4:            digit = 4'd4;
            SEG_5:            digit = 4'd5;
            SEG_6:            digit = 4'd6;
            SEG_7:            digit = 4'd7;
            SEG_8:            digit = 4'd8;
            SEG_9, SEG_9_ALT: digit = 4'd9;
            default:          valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_binary.sv
// Converts NDIG seven-segment patterns to an unsigned binary value: parallel
// segment decode to BCD, then BIN_W cycles of reverse double-dabble.
//
// state    | meaning
// S_IDLE   | ready for a new word, seg_in captured on in_valid
// S_DECODE | decode captured patterns, load shift register or flag error
// S_SHIFT  | one right shift plus nibble correction per cycle, BIN_W cycles
// S_DONE   | result presented, held until out_ready
module seg7_to_binary
    import seg7_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int BIN_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NDIG*7-1:0] seg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  bin_out,
    output logic              err
);

    localparam int BCD_W = NDIG * 4;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    s2b_state_t        state;
    s2b_state_t        state_nxt;
    logic [NDIG*7-1:0] seg_q;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_shift;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;
    logic [BIN_W-1:0]  bin_q;
    logic              err_q;
    logic [BCD_W-1:0]  bcd_all;
    logic [NDIG-1:0]   dig_ok;
    logic              all_ok;
    logic              last_shift;

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg7_decode u_dec (
            .seg   (seg_q[g*7 +: 7]),
            .digit (bcd_all[g*4 +: 4]),
            .valid (dig_ok[g])
        );
    end

    assign all_ok     = &dig_ok;
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // BCD sits above the binary field; each shift moves the BCD lsb into the binary msb.
    always_comb begin
        sr_shift = sr >> 1;
        sr_adj   = sr_shift;
        for (int i = 0; i < NDIG; i++) begin
            sr_adj[BIN_W + 4*i +: 4] = dd_adjust(sr_shift[BIN_W + 4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = all_ok ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                if (last_shift) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= '0;
            sr    <= '0;
            cnt   <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        seg_q <= seg_in;
                    end
                end
                S_DECODE: begin
                    if (all_ok) begin
                        sr    <= {bcd_all, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                        bin_q <= '0;
                    end
                end
                S_SHIFT: begin
                    sr  <= sr_adj;
                    cnt <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        bin_q <= sr_adj[BIN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bin_out = bin_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg7_to_binary.sv
// Self-checking bench for seg7_to_binary: directed cases, backpressure,
// mid-conversion reset, randomized words and back-to-back throughput.
module tb_seg7_to_binary;
    import seg7_pkg::*;

    localparam int NDIG  = 3;
    localparam int BIN_W = 10;
    localparam int LAT_OK  = BIN_W + 2;
    localparam int LAT_ERR = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [NDIG*7-1:0] seg_in = '0;
    logic              in_ready;
    logic              out_valid;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_q[$];
    logic [BIN_W:0] out_q[$];

    logic [6:0] codes [12] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6,
                               SEG_7, SEG_8, SEG_9, SEG_9_ALT, SEG_BLANK};
    int         vals  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 0};

    seg7_to_binary #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seg_in    (seg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
        if (rst_n && out_valid && out_ready) out_q.push_back({err, bin_out});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic void ref_model(input logic [NDIG*7-1:0] w, output int v, output bit e);
        int scale;
        int d;
        v = 0;
        e = 0;
        scale = 1;
        for (int i = 0; i < NDIG; i++) begin
            d = -1;
            for (int k = 0; k < 12; k++)
                if (codes[k] == w[i*7 +: 7]) d = vals[k];
            if (d < 0) e = 1;
            else v += d * scale;
            scale *= 10;
        end
        if (e) v = 0;
    endfunction

    function automatic logic [NDIG*7-1:0] rand_word(input bit allow_bad);
        logic [NDIG*7-1:0] w;
        int r;
        for (int i = 0; i < NDIG; i++) begin
            r = $urandom_range(0, 29);
            if (r < 12) w[i*7 +: 7] = codes[r];
            else if (r < 28 || !allow_bad) w[i*7 +: 7] = codes[$urandom_range(0, 9)];
            else w[i*7 +: 7] = 7'($urandom);
        end
        return w;
    endfunction

    task automatic convert(input logic [NDIG*7-1:0] w, output logic [BIN_W-1:0] b,
                           output logic e, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        seg_in   = w;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            b = '0;
            e = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seg_in   = 21'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = -1;
        b = bin_out;
        e = err;
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (bin_out !== '0) begin fails++; $display("FAIL reset_bin_out: got %0d expected 0", bin_out); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [NDIG*7-1:0] words [6];
        int                exp_v [6] = '{81, 999, 0, 7, 402, 0};
        bit                exp_e [6] = '{0, 0, 0, 0, 0, 1};
        logic [BIN_W-1:0]  b;
        logic              e;
        int                lat;
        words[0] = {SEG_0, SEG_8, SEG_1};
        words[1] = {SEG_9, SEG_9, SEG_9};
        words[2] = {SEG_0, SEG_0, SEG_0};
        words[3] = {SEG_BLANK, SEG_BLANK, SEG_7};
        words[4] = {SEG_4, SEG_BLANK, SEG_2};
        words[5] = {SEG_3, 7'b0101010, SEG_1};
        for (int i = 0; i < 6; i++) begin
            convert(words[i], b, e, lat);
            tests++; if (lat !== (exp_e[i] ? LAT_ERR : LAT_OK)) begin fails++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, exp_e[i] ? LAT_ERR : LAT_OK); end
            tests++; if (b !== BIN_W'(exp_v[i])) begin fails++; $display("FAIL directed%0d_bin: got %0d expected %0d", i, b, exp_v[i]); end
            tests++; if (e !== exp_e[i]) begin fails++; $display("FAIL directed%0d_err: got %b expected %b", i, e, exp_e[i]); end
            pop();
        end
    endtask

    task automatic test_backpressure();
        logic [BIN_W-1:0] b;
        logic             e;
        int               lat;
        int               acc_before;
        convert({SEG_5, SEG_5, SEG_5}, b, e, lat);
        tests++; if (b !== BIN_W'(555)) begin fails++; $display("FAIL bp_bin: got %0d expected 555", b); end
        acc_before = acc_q.size();
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            seg_in   = 21'($urandom);
            @(negedge clk);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, out_valid); end
            tests++; if (bin_out !== BIN_W'(555) || err !== 1'b0) begin fails++; $display("FAIL bp_hold_data%0d: got %0d/%b expected 555/0", i, bin_out, err); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, in_ready); end
        end
        in_valid = 1'b0;
        tests++; if (acc_q.size() !== acc_before) begin fails++; $display("FAIL bp_no_accept: got %0d accepts expected %0d", acc_q.size(), acc_before); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        convert({SEG_0, SEG_4, SEG_2}, b, e, lat);
        tests++; if (b !== BIN_W'(42) || e !== 1'b0 || lat !== LAT_OK) begin fails++; $display("FAIL bp_next_word: got %0d/%b lat %0d expected 42/0 lat %0d", b, e, lat, LAT_OK); end
        pop();
    endtask

    task automatic test_reset_mid();
        logic [BIN_W-1:0] b;
        logic             e;
        int               lat;
        int               seen;
        @(negedge clk);
        seg_in   = {SEG_8, SEG_6, SEG_4};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        tests++; if (bin_out !== '0) begin fails++; $display("FAIL rstmid_bin_out: got %0d expected 0", bin_out); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_output: got %0d valid cycles expected 0", seen); end
        convert({SEG_1, SEG_2, SEG_3}, b, e, lat);
        tests++; if (b !== BIN_W'(123) || e !== 1'b0 || lat !== LAT_OK) begin fails++; $display("FAIL rstmid_after: got %0d/%b lat %0d expected 123/0 lat %0d", b, e, lat, LAT_OK); end
        pop();
    endtask

    task automatic test_random();
        logic [NDIG*7-1:0] w;
        logic [BIN_W-1:0]  b;
        logic              e;
        int                lat;
        int                ev;
        bit                ee;
        for (int i = 0; i < 40; i++) begin
            w = rand_word(1'b1);
            ref_model(w, ev, ee);
            convert(w, b, e, lat);
            tests++; if (b !== BIN_W'(ev) || e !== ee) begin fails++; $display("FAIL random%0d: word %h got %0d/%b expected %0d/%b", i, w, b, e, ev, ee); end
            tests++; if (lat !== (ee ? LAT_ERR : LAT_OK)) begin fails++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, ee ? LAT_ERR : LAT_OK); end
            pop();
        end
    endtask

    task automatic test_back_to_back();
        logic [NDIG*7-1:0] w [3];
        int                ev;
        bit                ee;
        int                guard;
        acc_q.delete();
        out_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) w[k] = rand_word(1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seg_in   = w[k];
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (out_q.size() < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        tests++; if (out_q.size() !== 3 || acc_q.size() !== 3) begin fails++; $display("FAIL b2b_count: got %0d results %0d accepts expected 3/3", out_q.size(), acc_q.size()); end
        for (int k = 0; k < 3 && k < out_q.size(); k++) begin
            ref_model(w[k], ev, ee);
            tests++; if (out_q[k] !== {ee, BIN_W'(ev)}) begin fails++; $display("FAIL b2b_result%0d: got %h expected %h", k, out_q[k], {ee, BIN_W'(ev)}); end
        end
        for (int k = 1; k < 3 && k < acc_q.size(); k++) begin
            tests++; if (acc_q[k] - acc_q[k-1] !== BIN_W + 3) begin fails++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, acc_q[k] - acc_q[k-1], BIN_W + 3); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
